// File: rtl/packed_dot_engine_if.sv
// packed_dot_engine_if: controller handshake plus input-SRAM and weight-memory ports of packed_dot_engine.
interface packed_dot_engine_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 16
);
    logic              dut_run;
    logic              dut_busy;
    logic [ADDR_W-1:0] dut_sram_read_address;
    logic [DATA_W-1:0] sram_dut_read_data;
    logic [ADDR_W-1:0] dut_wmem_read_address;
    logic [DATA_W-1:0] wmem_dut_read_data;
    logic [ADDR_W-1:0] dut_sram_write_address;
    logic [DATA_W-1:0] dut_sram_write_data;
    logic              dut_sram_write_enable;
    modport slave (
        input  dut_run, sram_dut_read_data, wmem_dut_read_data,
        output dut_busy, dut_sram_read_address, dut_wmem_read_address,
               dut_sram_write_address, dut_sram_write_data, dut_sram_write_enable
    );
    modport master (
        output dut_run, sram_dut_read_data, wmem_dut_read_data,
        input  dut_busy, dut_sram_read_address, dut_wmem_read_address,
               dut_sram_write_address, dut_sram_write_data, dut_sram_write_enable
    );
endinterface

// File: rtl/packed_dot_engine.sv
// packed_dot_engine: header-driven signed dot product over packed 2/4/8/16-bit elements, one result write.
// Defining PACKED_DOT_SATURATE_EN saturates the result to signed DATA_W instead of truncating it.
module packed_dot_engine #(
    parameter int                ADDR_W    = 12,
    parameter int                DATA_W    = 16,
    parameter int                ACC_W     = 32,
    parameter int                MAX_ELEMS = 1024,
    parameter logic [ADDR_W-1:0] OUT_ADDR  = 12'hFFF
) (
    input logic                clk,
    input logic                reset_b,
    packed_dot_engine_if.slave bus
);
    localparam int CNT_W = $clog2(MAX_ELEMS + 1);
    localparam int OFF_W = $clog2(DATA_W);
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, HDR2, FETCH, MAC, WRITE} state_t;
    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         n_q, cnt_q;
    logic [OFF_W:0]           wi_q, ww_q;
    logic [OFF_W-1:0]         oi_q, ow_q, oi_n, ow_n;
    logic [ADDR_W-1:0]        ai_q, aw_q, pi_q, pw_q;
    logic [DATA_W-1:0]        xi_q, xw_q, xi, xw, result;
    logic signed [DATA_W-1:0] ei, ew;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     last, fetch;
    function automatic logic [OFF_W:0] width_dec(input logic [DATA_W-1:0] w);
        return (w == 2 || w == 4 || w == 8) ? w[OFF_W:0] : (OFF_W+1)'(DATA_W);
    endfunction
    function automatic logic signed [DATA_W-1:0] unpack(input logic [DATA_W-1:0] word,
                                                        input logic [OFF_W-1:0] off,
                                                        input logic [OFF_W:0] w);
        logic [DATA_W-1:0] s;
        s = word >> off;
        return w == 2 ? {{(DATA_W-2){s[1]}}, s[1:0]} :
               w == 4 ? {{(DATA_W-4){s[3]}}, s[3:0]} :
               w == 8 ? {{(DATA_W-8){s[7]}}, s[7:0]} : s;
    endfunction
    // An operand whose bit offset is 0 takes the word arriving this cycle; otherwise its held word
    assign xi    = oi_q == 0 ? bus.sram_dut_read_data : xi_q;
    assign xw    = ow_q == 0 ? bus.wmem_dut_read_data : xw_q;
    assign ei    = unpack(xi, oi_q, wi_q);
    assign ew    = unpack(xw, ow_q, ww_q);
    assign prod  = ei * ew;
    assign oi_n  = state_q == MAC ? oi_q + wi_q[OFF_W-1:0] : oi_q;
    assign ow_n  = state_q == MAC ? ow_q + ww_q[OFF_W-1:0] : ow_q;
    assign fetch = oi_n == 0 || ow_n == 0;
    assign last  = cnt_q + 1'b1 == n_q;
    assign bus.dut_sram_read_address = ai_q;
    assign bus.dut_wmem_read_address = aw_q;
`ifdef PACKED_DOT_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;
    assign result = acc_q > SAT_MAX ? SAT_MAX[DATA_W-1:0] :
                    acc_q < SAT_MIN ? SAT_MIN[DATA_W-1:0] : acc_q[DATA_W-1:0];
`else
    assign result = acc_q[DATA_W-1:0];
`endif
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) state_q <= IDLE;
        else          state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = bus.dut_run ? HDR0 : IDLE;
            HDR0:    state_d = HDR1;
            HDR1:    state_d = HDR2;
            HDR2:    state_d = n_q == 0 ? WRITE : fetch ? FETCH : MAC;
            FETCH:   state_d = MAC;
            MAC:     state_d = last ? WRITE : fetch ? FETCH : MAC;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        bus.dut_busy               = state_q != IDLE;
        bus.dut_sram_write_enable  = state_q == WRITE;
        bus.dut_sram_write_address = state_q == WRITE ? OUT_ADDR : '0;
        bus.dut_sram_write_data    = state_q == WRITE ? result : '0;
    end
    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            n_q   <= '0;
            cnt_q <= '0;
            wi_q  <= '0;
            ww_q  <= '0;
            oi_q  <= '0;
            ow_q  <= '0;
            ai_q  <= '0;
            aw_q  <= '0;
            pi_q  <= '0;
            pw_q  <= '0;
            xi_q  <= '0;
            xw_q  <= '0;
            acc_q <= '0;
        end else begin
            if (state_d == HDR0) begin
                ai_q <= '0;
                aw_q <= '0;
                oi_q <= '0;
                ow_q <= '0;
                pi_q <= ADDR_W'(2);
                pw_q <= ADDR_W'(2);
            end
            if (state_d == HDR1) begin
                ai_q <= ADDR_W'(1);
                aw_q <= ADDR_W'(1);
            end
            if (state_q == HDR1)
                n_q <= bus.sram_dut_read_data > MAX_ELEMS ? CNT_W'(MAX_ELEMS) : bus.sram_dut_read_data[CNT_W-1:0];
            if (state_q == HDR2) begin
                wi_q  <= width_dec(bus.sram_dut_read_data);
                ww_q  <= width_dec(bus.wmem_dut_read_data);
                acc_q <= '0;
                cnt_q <= '0;
            end
            if (state_d == FETCH && oi_n == 0) begin
                ai_q <= pi_q;
                pi_q <= pi_q + 1'b1;
            end
            if (state_d == FETCH && ow_n == 0) begin
                aw_q <= pw_q;
                pw_q <= pw_q + 1'b1;
            end
            if (state_q == MAC) begin
                xi_q  <= xi;
                xw_q  <= xw;
                oi_q  <= oi_n;
                ow_q  <= ow_n;
                acc_q <= acc_q + ACC_W'(prod);
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_packed_dot_engine.sv
// tb_packed_dot_engine: directed scenarios for packed_dot_engine with synchronous memory models.
module tb_packed_dot_engine;
    logic        clk = 1'b0;
    logic        reset_b;
    logic [15:0] sram [0:4095];
    logic [15:0] wmem [0:4095];
    int          total = 0, bad = 0;
    int          busy_cnt = 0, wr_cnt = 0, wr_busy = 0, hi_reads = 0;
    logic [11:0] wr_addr;
    logic [15:0] wr_data;

    packed_dot_engine_if #(.ADDR_W(12), .DATA_W(16)) bus ();
    packed_dot_engine dut (.clk(clk), .reset_b(reset_b), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.sram_dut_read_data <= sram[bus.dut_sram_read_address];
        bus.wmem_dut_read_data <= wmem[bus.dut_wmem_read_address];
    end

    always @(negedge clk) begin
        if (bus.dut_busy) busy_cnt++;
        if (bus.dut_busy && (bus.dut_sram_read_address > 1 || bus.dut_wmem_read_address > 1)) hi_reads++;
        if (bus.dut_sram_write_enable) begin
            wr_cnt++;
            wr_addr = bus.dut_sram_write_address;
            wr_data = bus.dut_sram_write_data;
            wr_busy = busy_cnt;
        end
    end

    task automatic clear_counts();
        busy_cnt = 0;
        wr_cnt   = 0;
        wr_busy  = 0;
        hi_reads = 0;
        wr_addr  = '0;
        wr_data  = '0;
    endtask

    task automatic run_op(input string name, input logic [15:0] exp_data, input int exp_busy, input bit pulse);
        bit done = 0;
        clear_counts();
        @(negedge clk) bus.dut_run = 1'b1;
        @(negedge clk) bus.dut_run = 1'b0;
        for (int i = 0; i < 4000 && !done; i++) begin
            @(negedge clk);
            #1;
            if (pulse) bus.dut_run = (i == 1);
            done = !bus.dut_busy;
        end
        bus.dut_run = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL %s timeout: busy still high after 4000 cycles, want low", name); end
        total++;
        if (wr_cnt !== 1) begin bad++; $display("FAIL %s write count: got %0d want 1", name, wr_cnt); end
        total++;
        if (wr_addr !== 12'hFFF) begin bad++; $display("FAIL %s write addr: got %h want fff", name, wr_addr); end
        total++;
        if (wr_data !== exp_data) begin bad++; $display("FAIL %s write data: got %h want %h", name, wr_data, exp_data); end
        total++;
        if (busy_cnt !== exp_busy) begin bad++; $display("FAIL %s busy cycles: got %0d want %0d", name, busy_cnt, exp_busy); end
        total++;
        if (wr_busy !== exp_busy) begin bad++; $display("FAIL %s strobe cycle: got busy cycle %0d want %0d", name, wr_busy, exp_busy); end
    endtask

    task automatic check_outputs_zero(input string name);
        total++;
        if ({bus.dut_busy, bus.dut_sram_write_enable} !== 2'b00) begin
            bad++; $display("FAIL %s busy/we: got %b want 00", name, {bus.dut_busy, bus.dut_sram_write_enable});
        end
        total++;
        if ({bus.dut_sram_read_address, bus.dut_wmem_read_address} !== 24'h0) begin
            bad++; $display("FAIL %s read addrs: got %h/%h want 0/0", name, bus.dut_sram_read_address, bus.dut_wmem_read_address);
        end
        total++;
        if ({bus.dut_sram_write_address, bus.dut_sram_write_data} !== 28'h0) begin
            bad++; $display("FAIL %s write addr/data: got %h/%h want 0/0", name, bus.dut_sram_write_address, bus.dut_sram_write_data);
        end
    endtask

    task automatic load_basic();
        sram[0] = 16'd4;  sram[1] = 16'd8;  sram[2] = 16'h0201; sram[3] = 16'h0403;
        wmem[0] = 16'd9;  wmem[1] = 16'd8;  wmem[2] = 16'h0101; wmem[3] = 16'h0101;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk) reset_b = 1'b1;
    endtask

    task automatic test_basic();
        load_basic();
        run_op("basic8", 16'h000A, 10, 1'b0);
    endtask

    task automatic test_mixed();
        sram[0] = 16'd8; sram[1] = 16'd2; sram[2] = 16'hFFFF;
        wmem[0] = 16'd0; wmem[1] = 16'd16;
        for (int i = 2; i < 10; i++) wmem[i] = 16'h0001;
        run_op("mixed", 16'hFFF8, 20, 1'b0);
    endtask

    task automatic test_zero_count();
        sram[0] = 16'd0; sram[1] = 16'd8; wmem[0] = 16'd5; wmem[1] = 16'd8;
        run_op("zero", 16'h0000, 4, 1'b0);
        total++;
        if (hi_reads !== 0) begin bad++; $display("FAIL zero data reads: got %0d cycles want 0", hi_reads); end
    endtask

    task automatic test_overflow();
        sram[0] = 16'd2; sram[1] = 16'd16; sram[2] = 16'h7FFF; sram[3] = 16'h7FFF;
        wmem[1] = 16'd16; wmem[2] = 16'h7FFF; wmem[3] = 16'h7FFF;
`ifdef PACKED_DOT_SATURATE_EN
        run_op("overflow", 16'h7FFF, 8, 1'b0);
`else
        run_op("overflow", 16'h0002, 8, 1'b0);
`endif
    endtask

    task automatic test_illegal_width();
        sram[0] = 16'd1; sram[1] = 16'd5; sram[2] = 16'h0003;
        wmem[1] = 16'd5; wmem[2] = 16'h0004;
        run_op("width5", 16'h000C, 6, 1'b1);
        sram[0] = 16'd2; sram[1] = 16'd3; sram[2] = 16'h0023; sram[3] = 16'h0002;
        wmem[1] = 16'd0; wmem[2] = 16'h0004; wmem[3] = 16'hFFFF;
        run_op("width3_0", 16'h008A, 8, 1'b0);
    endtask

    task automatic test_back_to_back();
        bit done = 0;
        sram[0] = 16'd2; sram[1] = 16'd4; sram[2] = 16'h00F7;
        wmem[1] = 16'd8; wmem[2] = 16'h03FE;
        clear_counts();
        @(negedge clk) bus.dut_run = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            #1;
            if (wr_cnt == 2) begin bus.dut_run = 1'b0; done = 1; end
        end
        bus.dut_run = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if (!done) begin bad++; $display("FAIL b2b timeout: writes %0d want 2", wr_cnt); end
        total++;
        if (wr_cnt !== 2) begin bad++; $display("FAIL b2b write count: got %0d want 2", wr_cnt); end
        total++;
        if (busy_cnt !== 14) begin bad++; $display("FAIL b2b busy cycles: got %0d want 14", busy_cnt); end
        total++;
        if (wr_data !== 16'hFFEF) begin bad++; $display("FAIL b2b write data: got %h want ffef", wr_data); end
    endtask

    task automatic test_reset_mid_mac();
        int guard = 0;
        load_basic();
        clear_counts();
        @(negedge clk) bus.dut_run = 1'b1;
        @(negedge clk) bus.dut_run = 1'b0;
        while (busy_cnt < 8 && guard < 100) begin
            @(negedge clk);
            #1;
            guard++;
        end
        total++;
        if (bus.dut_sram_read_address !== 12'd3) begin
            bad++; $display("FAIL midmac addr before reset: got %h want 003", bus.dut_sram_read_address);
        end
        #2 reset_b = 1'b0;
        #1;
        check_outputs_zero("midmac reset");
        repeat (2) @(negedge clk);
        reset_b = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        total++;
        if (wr_cnt !== 0 || bus.dut_busy !== 1'b0) begin
            bad++; $display("FAIL midmac after reset: writes %0d busy %b want 0 0", wr_cnt, bus.dut_busy);
        end
        run_op("rerun", 16'h000A, 10, 1'b0);
    endtask

    initial begin
        reset_b     = 1'b0;
        bus.dut_run = 1'b0;
        test_reset();
        test_basic();
        test_mixed();
        test_zero_count();
        test_overflow();
        test_illegal_width();
        test_back_to_back();
        test_reset_mid_mac();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
